sw_cmd_conditioner: RTL and testbench
=====================================

// Module: sw_cmd_conditioner
// PURPOSE
//   Upstream stage of the flip-counter/BCD display path. Synchronises and debounces
//   the four raw command switches (add4, add8, add12, sub8), generates the slow step
//   tick (replaces the bare cnt[23] divider), and presents one prioritised command per
//   tick to the counter stage over a valid/ready handshake. Counts ticks lost to backpressure.
// PARAMETERS
//   DB_CYCLES  1_000_000  consecutive cycles a synced input must differ before stable level flips (20 ms @ 50 MHz)
//   DB_W       20         debounce counter width; must satisfy 2**DB_W >= DB_CYCLES
//   TICK_W     24         step-tick divider width; one tick per 2**TICK_W cycles
// PORTS
//   clk          in   1  system clock (CLOCK_50 at top level)
//   rst_n        in   1  asynchronous, active-low reset
//   sw_raw       in   4  raw switches: [0]=add4 [1]=add8 [2]=add12 [3]=sub8, asynchronous
//   sw_stable    out  4  debounced switch levels (for LEDs / debug)
//   step_tick    out  1  one-cycle pulse, every 2**TICK_W cycles
//   cmd_valid    out  1  command pending for downstream
//   cmd_op       out  2  00=add4 01=add8 10=add12 11=sub8; held stable while cmd_valid && !cmd_ready
//   cmd_ready    in   1  downstream accepts cmd when cmd_valid && cmd_ready at a rising clk edge
//   overrun_cnt  out  8  ticks dropped because a command was still pending; saturates at 255
// BEHAVIOUR
//   Reset (rst_n=0, async): all flops 0 -> sw_stable=0, step_tick=0, cmd_valid=0, cmd_op=0,
//     overrun_cnt=0, sync/debounce/tick counters 0. Deassertion is taken synchronously by all flops.
//   Sync: two flops per bit; sw_raw -> synced latency 2 cycles.
//   Debounce (per bit, independent): if synced==stable, counter<=0. Else counter<=counter+1;
//     when counter==DB_CYCLES-1 and still differing, stable<=synced and counter<=0.
//     Any cycle with synced==stable restarts the count. Total latency raw->sw_stable = 2+DB_CYCLES cycles.
//   Tick: free-running TICK_W-bit counter, wraps; step_tick=1 in the cycle the counter is all-ones
//     (registered, no glitch). First tick 2**TICK_W-1 cycles after reset release.
//   Command load, evaluated on cycles with step_tick=1:
//     - free = !cmd_valid || cmd_ready (slot empty or being accepted this edge).
//     - sw_stable==0: no load; if not free, cmd unaffected and no overrun counted.
//     - sw_stable!=0 && free: cmd_op <= priority encode (add4 > add8 > add12 > sub8), cmd_valid<=1.
//     - sw_stable!=0 && !free: command dropped, overrun_cnt <= sat(overrun_cnt+1); cmd_op unchanged.
//   Accept without tick: cmd_valid && cmd_ready -> cmd_valid<=0 next edge; cmd_op keeps last value.
//   Simultaneous tick + accept + nonzero sw_stable: new command loaded, cmd_valid stays 1 (no bubble).
//   cmd_ready while cmd_valid=0: ignored.
//   Level semantics: a held switch issues one command per tick (auto-repeat), matching the counter's stepping.
//   sw_stable changes while a command is pending never alter cmd_op.
// STRUCTURE
//   Shared package sw_cmd_pkg: OP_ADD4/OP_ADD8/OP_ADD12/OP_SUB8 2-bit localparams, switch-bit index
//     constants; consumed also by the counter stage's decoder.
//   Sub-module debounce_bit (2-flop sync + DB_W counter + stable flop), params DB_CYCLES/DB_W,
//     instantiated 4x by generate. Tick divider, priority encoder, handshake, overrun counter inline.
// TESTING (bench parameters DB_CYCLES=4, DB_W=3, TICK_W=4)
//   1 Reset: assert rst_n=0 mid-run with sw_raw=4'hF, cmd_valid=1 -> all outputs 0 same cycle, no tick for 15 cycles after release.
//   2 Bounce: sw_raw[0] toggles with 2-cycle pulses for 20 cycles -> sw_stable[0] stays 0; then held 1 -> sw_stable[0]=1 exactly 6 cycles after the edge.
//   3 Priority: sw_stable=4'b1110 at tick, cmd_ready=1 -> cmd_valid=1, cmd_op=01; then 4'b1111 -> cmd_op=00; 4'b1000 -> 11.
//   4 Backpressure: add12 held, cmd_ready=0 across 4 ticks -> cmd_op=10 held, overrun_cnt=3; cmd_ready=1 -> cmd_valid=0 next edge.
//   5 Tick+accept same cycle with add8 held -> cmd_valid remains 1, cmd_op=01, overrun_cnt unchanged.
//   6 Saturation: cmd_ready=0, add4 held for 300 ticks -> overrun_cnt=255, no wrap.

Source files
------------

// File: rtl/sw_cmd_pkg.sv
// rtl/sw_cmd_pkg.sv - command opcodes, switch indices and priority encoder shared with the counter stage
package sw_cmd_pkg;

  localparam logic [1:0] OP_ADD4  = 2'b00;
  localparam logic [1:0] OP_ADD8  = 2'b01;
  localparam logic [1:0] OP_ADD12 = 2'b10;
  localparam logic [1:0] OP_SUB8  = 2'b11;

  localparam int SW_ADD4  = 0;
  localparam int SW_ADD8  = 1;
  localparam int SW_ADD12 = 2;
  localparam int SW_SUB8  = 3;

  // Lowest switch index wins; an all-zero input never reaches this in practice.
  function automatic logic [1:0] prio_op(input logic [3:0] sw);
    logic [1:0] op;
    op = OP_ADD4;
    if (sw[SW_ADD4])       op = OP_ADD4;
    else if (sw[SW_ADD8])  op = OP_ADD8;
    else if (sw[SW_ADD12]) op = OP_ADD12;
    else if (sw[SW_SUB8])  op = OP_SUB8;
    return op;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser plus counter debouncer for one switch
module debounce_bit #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_cmd_conditioner.sv
// rtl/sw_cmd_conditioner.sv - debounced switches to one prioritised command per step tick
module sw_cmd_conditioner
  import sw_cmd_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W      = 20,
  parameter int TICK_W    = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_raw,
  output logic [3:0] sw_stable,
  output logic       step_tick,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  input  logic       cmd_ready,
  output logic [7:0] overrun_cnt
);

  localparam logic [TICK_W-1:0] TICK_PRE = {{(TICK_W-1){1'b1}}, 1'b0};

  logic [TICK_W-1:0] tick_cnt;
  logic              slot_free;

  for (genvar g = 0; g < 4; g++) begin : g_db
    debounce_bit #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sw_raw[g]),
      .stable(sw_stable[g])
    );
  end

  // step_tick is registered one count early so it lines up with the all-ones state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      step_tick <= 1'b0;
    end else begin
      tick_cnt  <= tick_cnt + 1'b1;
      step_tick <= (tick_cnt == TICK_PRE);
    end
  end

  assign slot_free = !cmd_valid || cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid   <= 1'b0;
      cmd_op      <= OP_ADD4;
      overrun_cnt <= '0;
    end else if (step_tick && (sw_stable != 4'b0000)) begin
      if (slot_free) begin
        cmd_valid <= 1'b1;
        cmd_op    <= prio_op(sw_stable);
      end else if (overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 1'b1;
      end
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sw_cmd_conditioner.sv
// tb/tb_sw_cmd_conditioner.sv - directed self-checking bench for sw_cmd_conditioner
module tb_sw_cmd_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_raw = 4'h0;
  logic [3:0] sw_stable;
  logic       step_tick;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready = 1'b0;
  logic [7:0] overrun_cnt;

  int errors = 0;
  int checks = 0;

  sw_cmd_conditioner #(.DB_CYCLES(4), .DB_W(3), .TICK_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_stable  (sw_stable),
    .step_tick  (step_tick),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset with given switches applied, then release mid-cycle.
  task automatic do_reset(input logic [3:0] sw, input logic rdy);
    @(negedge clk);
    rst_n     = 1'b0;
    sw_raw    = sw;
    cmd_ready = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the negedge of a cycle with step_tick high.
  task automatic wait_tick_pre();
    int n;
    n = 0;
    @(negedge clk);
    while (!step_tick && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!step_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: step_tick=%0b required 1 within 40 cycles", step_tick);
    end
  endtask

  task automatic wait_tick();
    wait_tick_pre();
    cycle();
  endtask

  task automatic test_reset();
    int bad;
    do_reset(4'hF, 1'b0);
    repeat (8) cycle();
    wait_tick();
    checks++;
    if (cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_valid: cmd_valid=%0b required 1", cmd_valid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sw_stable, step_tick, cmd_valid, cmd_op, overrun_cnt} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: sw_stable=%h tick=%0b valid=%0b op=%0d ovr=%0d required all 0",
               sw_stable, step_tick, cmd_valid, cmd_op, overrun_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 1; i <= 14; i++) begin
      cycle();
      if (step_tick !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_no_early_tick: %0d early ticks required 0", bad);
    end
    cycle();
    checks++;
    if (step_tick !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_tick: step_tick=%0b required 1 at cycle 15", step_tick);
    end
  endtask

  task automatic test_bounce();
    int bad;
    do_reset(4'h0, 1'b0);
    cycle();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      sw_raw[0] = ((i / 2) % 2) == 0;
      cycle();
      if (sw_stable[0] !== 1'b0) bad++;
    end
    sw_raw[0] = 1'b0;
    repeat (5) begin
      cycle();
      if (sw_stable[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bounce_filtered: %0d cycles with sw_stable[0]=1 required 0", bad);
    end
    sw_raw[0] = 1'b1;
    bad = 0;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (sw_stable[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bounce_early: sw_stable[0] rose %0d cycles early required 0", bad);
    end
    cycle();
    checks++;
    if (sw_stable[0] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_latency: sw_stable[0]=%0b required 1 at cycle 6", sw_stable[0]);
    end
  endtask

  task automatic prio_case(input logic [3:0] sw, input logic [1:0] exp_op);
    sw_raw = sw;
    repeat (8) cycle();
    checks++;
    if (sw_stable !== sw) begin
      errors++;
      $display("FAIL prio_stable: sw_stable=%b required %b", sw_stable, sw);
    end
    wait_tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== exp_op) begin
      errors++;
      $display("FAIL prio_op_%b: valid=%0b op=%b required valid=1 op=%b", sw, cmd_valid, cmd_op, exp_op);
    end
  endtask

  task automatic test_priority();
    do_reset(4'h0, 1'b1);
    prio_case(4'b1110, 2'b01);
    prio_case(4'b1111, 2'b00);
    prio_case(4'b1000, 2'b11);
  endtask

  task automatic test_backpressure();
    do_reset(4'b0100, 1'b0);
    wait_tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 2'b10 || overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL bp_first: valid=%0b op=%b ovr=%0d required 1 10 0", cmd_valid, cmd_op, overrun_cnt);
    end
    repeat (3) wait_tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 2'b10 || overrun_cnt !== 8'd3) begin
      errors++;
      $display("FAIL bp_held: valid=%0b op=%b ovr=%0d required 1 10 3", cmd_valid, cmd_op, overrun_cnt);
    end
    cmd_ready = 1'b1;
    cycle();
    checks++;
    if (cmd_valid !== 1'b0 || cmd_op !== 2'b10 || overrun_cnt !== 8'd3) begin
      errors++;
      $display("FAIL bp_accept: valid=%0b op=%b ovr=%0d required 0 10 3", cmd_valid, cmd_op, overrun_cnt);
    end
  endtask

  task automatic test_idle_pending();
    do_reset(4'b0001, 1'b0);
    wait_tick();
    sw_raw = 4'h0;
    repeat (2) wait_tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 2'b00 || overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL idle_pending: valid=%0b op=%b ovr=%0d required 1 00 0", cmd_valid, cmd_op, overrun_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(4'b0010, 1'b0);
    wait_tick();
    wait_tick_pre();
    cmd_ready = 1'b1;
    cycle();
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 2'b01 || overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_no_bubble: valid=%0b op=%b ovr=%0d required 1 01 0", cmd_valid, cmd_op, overrun_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset(4'b0001, 1'b0);
    repeat (300) wait_tick();
    checks++;
    if (overrun_cnt !== 8'd255 || cmd_valid !== 1'b1 || cmd_op !== 2'b00) begin
      errors++;
      $display("FAIL sat_overrun: ovr=%0d valid=%0b op=%b required 255 1 00", overrun_cnt, cmd_valid, cmd_op);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_priority();
    test_backpressure();
    test_idle_pending();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
